pixel_compositor: RTL and testbench
===================================

// Module: pixel_compositor
// PURPOSE
//  Parametrised, pipelined pixel compositor replacing the fixed combinational VGA mux.
//  Merges LAYERS overlay/wall sources plus a split background into one pixel.
//  Frame-synchronous layer mask and background split. Sync/visible delayed to stay
//  aligned with the pixel. Sits between the layer generators and the VGA pins in rbzero.
// PARAMETERS
//  LAYERS      3    number of layer inputs; index 0 = highest priority (debug, map, wall)
//  COLOR_BITS  6    bits per pixel (RRGGBB at default)
//  HBITS       10   width of hpos/split
//  PIPE        2    output latency in clocks, >=1
// PORTS
//  clk          in   1                  pixel clock
//  reset        in   1                  async, active-high
//  i_visible    in   1                  pixel is in the visible area
//  i_hsync      in   1                  active-high hsync
//  i_vsync      in   1                  active-high vsync
//  i_hpos       in   HBITS              current column
//  i_layer_en   in   LAYERS             per-layer pixel enable
//  i_layer_rgb  in   LAYERS*COLOR_BITS  layer k colour at [k*COLOR_BITS +: COLOR_BITS]
//  i_bg_left    in   COLOR_BITS         background when hpos < split
//  i_bg_right   in   COLOR_BITS         background when hpos >= split
//  i_cfg_wr     in   1                  1-cycle strobe: capture i_mask/i_split as pending config
//  i_mask       in   LAYERS             layer mask; 1 = layer may be shown
//  i_split      in   HBITS              background split column
//  o_rgb        out  COLOR_BITS         composited pixel
//  o_hsync      out  1                  i_hsync delayed PIPE clocks
//  o_vsync      out  1                  i_vsync delayed PIPE clocks
//  o_visible    out  1                  i_visible delayed PIPE clocks
//  o_layer_id   out  clog2(LAYERS+1)    winning layer index; LAYERS = background; 0 when blank
// BEHAVIOUR
//  Reset: o_rgb=0, o_hsync=0, o_vsync=0, o_visible=0, o_layer_id=0; all pipe stages 0;
//   active and pending mask = all ones, active and pending split = 320 (H_VIEW/2),
//   cfg_pending=0, vsync_q=0.
//  Config: i_cfg_wr latches pending mask/split, sets cfg_pending. Never affects mid-frame.
//  Frame edge: vsync_rise = i_vsync & ~vsync_q. On vsync_rise with cfg_pending: active <=
//   pending, cfg_pending <= 0. Without cfg_pending: active unchanged.
//  Simultaneous i_cfg_wr and vsync_rise: new i_mask/i_split bypass straight into active
//   that cycle; cfg_pending ends 0. Repeated i_cfg_wr before vsync: last write wins.
//  Stage 1 (registered): eff = i_layer_en & active_mask; winner = lowest set index of eff;
//   rgb = winner's colour; if eff==0 rgb = (i_hpos < active_split) ? i_bg_left : i_bg_right,
//   id = LAYERS. If i_visible==0: rgb=0, id=0 (blanking overrides everything).
//   Comparison unsigned, HBITS wide; split=0 => always right, split>=2^HBITS-1 bound honoured.
//  Stages 2..PIPE: plain delay of {rgb,id,hsync,vsync,visible}. Total latency exactly PIPE.
//  Sync/visible pass through the same stages, so all outputs are mutually aligned.
//  Reset mid-frame: outputs go to reset values immediately (async); first valid output
//   PIPE clocks after reset deassertion; config returns to defaults.
// STRUCTURE
//  Shared package/params include: COLOR_BITS default, H_VIEW, default split, layer index
//   constants (LAYER_DEBUG=0, LAYER_MAP=1, LAYER_WALL=2).
//  One sub-module: priority_select (combinational lowest-index one-hot -> index + colour mux).
//  Delay line: generate loop of PIPE-1 register stages; config block is separate always.
// TESTING
//  1 Reset: hold reset, drive activity -> all outputs 0; release, all layers off, visible,
//    hpos=100 -> o_rgb=i_bg_left(101010), id=3 after exactly 2 clocks.
//  2 Priority: en=3'b110, rgb{L2=000011,L1=001100} -> o_rgb=001100, id=1; en=3'b111 -> L0, id=0.
//  3 Mask timing: mid-frame cfg_wr mask=3'b110, en=3'b001 -> L0 still shown until vsync
//    rise; from the first pixel after the rise -> L1/background shown, id!=0.
//  4 Simultaneous: cfg_wr same cycle as vsync rise, split=10 -> hpos=9 left, hpos=10 right
//    from that frame; no extra frame of delay.
//  5 Blanking/alignment: i_visible=0 with en=3'b111 -> o_rgb=0, id=0; hsync pulse at input
//    cycle t appears on o_hsync at t+PIPE, matching rgb; rerun with PIPE=1 and PIPE=4.
//  6 Async reset mid-frame with pending config -> outputs 0 same cycle; pending discarded,
//    mask=all ones, split=320 after release.

Source files
------------

// File: rtl/pixel_compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_compositor_pkg
//  Description : Shared constants for the pixel compositor: default widths,
//                screen geometry, reset split column and layer indices.
//  Revision    : 1.0
// ============================================================================
package pixel_compositor_pkg;

    localparam int LAYER_DEBUG    = 0;
    localparam int LAYER_MAP      = 1;
    localparam int LAYER_WALL     = 2;
    localparam int LAYERS_DEF     = LAYER_WALL + 1;

    localparam int COLOR_BITS_DEF = 6;
    localparam int HBITS_DEF      = 10;
    localparam int H_VIEW         = 640;
    localparam int SPLIT_DEF      = H_VIEW / 2;

    function automatic int id_bits(input int layers);
        return $clog2(layers + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_compositor_if
//  Description : Pixel, sync and config bundle between the layer generators
//                (master) and the compositor (slave).
//  Revision    : 1.0
// ============================================================================
interface pixel_compositor_if
    import pixel_compositor_pkg::*;
#(
    parameter int LAYERS     = LAYERS_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF,
    parameter int HBITS      = HBITS_DEF
);
    localparam int ID_BITS = id_bits(LAYERS);

    logic                         i_visible;
    logic                         i_hsync;
    logic                         i_vsync;
    logic [HBITS-1:0]             i_hpos;
    logic [LAYERS-1:0]            i_layer_en;
    logic [LAYERS*COLOR_BITS-1:0] i_layer_rgb;
    logic [COLOR_BITS-1:0]        i_bg_left;
    logic [COLOR_BITS-1:0]        i_bg_right;
    logic                         i_cfg_wr;
    logic [LAYERS-1:0]            i_mask;
    logic [HBITS-1:0]             i_split;
    logic [COLOR_BITS-1:0]        o_rgb;
    logic                         o_hsync;
    logic                         o_vsync;
    logic                         o_visible;
    logic [ID_BITS-1:0]           o_layer_id;

    modport master (
        output i_visible, i_hsync, i_vsync, i_hpos, i_layer_en, i_layer_rgb,
               i_bg_left, i_bg_right, i_cfg_wr, i_mask, i_split,
        input  o_rgb, o_hsync, o_vsync, o_visible, o_layer_id
    );

    modport slave (
        input  i_visible, i_hsync, i_vsync, i_hpos, i_layer_en, i_layer_rgb,
               i_bg_left, i_bg_right, i_cfg_wr, i_mask, i_split,
        output o_rgb, o_hsync, o_vsync, o_visible, o_layer_id
    );

endinterface
`default_nettype wire

// File: rtl/pixel_compositor_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_compositor_priority_select
//  Description : Picks the lowest-index enabled layer and muxes its colour.
//  Revision    : 1.0
// ============================================================================
module pixel_compositor_priority_select
    import pixel_compositor_pkg::*;
#(
    parameter int LAYERS     = LAYERS_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF,
    parameter int ID_BITS    = id_bits(LAYERS_DEF)
) (
    input  logic [LAYERS-1:0]            i_eff,
    input  logic [LAYERS*COLOR_BITS-1:0] i_layer_rgb,
    output logic                         o_hit,
    output logic [ID_BITS-1:0]           o_idx,
    output logic [COLOR_BITS-1:0]        o_rgb
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        o_rgb = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (i_eff[k]) begin
                o_hit = 1'b1;
                o_idx = ID_BITS'(k);
                o_rgb = i_layer_rgb[k*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_compositor
//  Description : Pipelined layer/background compositor with frame-synchronous
//                mask and split config; sync and visible delayed alongside.
//  Revision    : 1.0
// ============================================================================
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int LAYERS     = LAYERS_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF,
    parameter int HBITS      = HBITS_DEF,
    parameter int PIPE       = 2
) (
    input  logic              clk,
    input  logic              reset,
    pixel_compositor_if.slave bus
);

    localparam int               ID_BITS   = id_bits(LAYERS);
    localparam int               SW        = COLOR_BITS + ID_BITS + 3;
    localparam logic [HBITS-1:0] SPLIT_RST = HBITS'(SPLIT_DEF);

    logic [LAYERS-1:0] act_mask_q, pend_mask_q;
    logic [HBITS-1:0]  act_split_q, pend_split_q;
    logic              cfg_pend_q;
    logic              vsync_q;
    logic              vsync_rise;

    assign vsync_rise = bus.i_vsync & ~vsync_q;

    // A write coinciding with the frame edge goes straight to the active set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_mask_q   <= '1;
            pend_mask_q  <= '1;
            act_split_q  <= SPLIT_RST;
            pend_split_q <= SPLIT_RST;
            cfg_pend_q   <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            vsync_q <= bus.i_vsync;
            if (bus.i_cfg_wr) begin
                pend_mask_q  <= bus.i_mask;
                pend_split_q <= bus.i_split;
            end
            if (vsync_rise && bus.i_cfg_wr) begin
                act_mask_q  <= bus.i_mask;
                act_split_q <= bus.i_split;
                cfg_pend_q  <= 1'b0;
            end else if (vsync_rise && cfg_pend_q) begin
                act_mask_q  <= pend_mask_q;
                act_split_q <= pend_split_q;
                cfg_pend_q  <= 1'b0;
            end else if (bus.i_cfg_wr) begin
                cfg_pend_q  <= 1'b1;
            end
        end
    end

    logic [LAYERS-1:0]     eff;
    logic                  hit;
    logic [ID_BITS-1:0]    sel_idx;
    logic [COLOR_BITS-1:0] sel_rgb;

    assign eff = bus.i_layer_en & act_mask_q;

    pixel_compositor_priority_select #(
        .LAYERS     (LAYERS),
        .COLOR_BITS (COLOR_BITS),
        .ID_BITS    (ID_BITS)
    ) u_priority_select (
        .i_eff       (eff),
        .i_layer_rgb (bus.i_layer_rgb),
        .o_hit       (hit),
        .o_idx       (sel_idx),
        .o_rgb       (sel_rgb)
    );

    logic [COLOR_BITS-1:0] rgb_d;
    logic [ID_BITS-1:0]    id_d;
    logic [SW-1:0]         stage1_d;
    logic [SW-1:0]         stage1_q;

    always_comb begin
        rgb_d = (bus.i_hpos < act_split_q) ? bus.i_bg_left : bus.i_bg_right;
        id_d  = ID_BITS'(LAYERS);
        if (hit) begin
            rgb_d = sel_rgb;
            id_d  = sel_idx;
        end
        if (!bus.i_visible) begin
            rgb_d = '0;
            id_d  = '0;
        end
    end

    assign stage1_d = {rgb_d, id_d, bus.i_hsync, bus.i_vsync, bus.i_visible};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q <= '0;
        end else begin
            stage1_q <= stage1_d;
        end
    end

    logic [SW-1:0] tap [1:PIPE];
    assign tap[1] = stage1_q;

    for (genvar s = 2; s <= PIPE; s++) begin : g_delay
        logic [SW-1:0] dly_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dly_q <= '0;
            end else begin
                dly_q <= tap[s-1];
            end
        end
        assign tap[s] = dly_q;
    end

    assign {bus.o_rgb, bus.o_layer_id, bus.o_hsync, bus.o_vsync, bus.o_visible} = tap[PIPE];

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_compositor
//  Description : Drives three compositors (PIPE 2/1/4) from one stimulus and
//                scores each against a reference model through per-DUT queues.
//  Revision    : 1.0
// ============================================================================
module tb_pixel_compositor;

    logic        clk;
    logic        reset;
    logic        visible, hsync, vsync, cfg_wr;
    logic [9:0]  hpos, split;
    logic [2:0]  en, mask;
    logic [17:0] lrgb;
    logic [5:0]  bgl, bgr;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] pk(input logic [5:0] rgb, input logic [1:0] id,
                                       input logic hs, input logic vs, input logic vis);
        return {rgb, id, hs, vs, vis};
    endfunction

    // Reference model: config state plus the expected stage-1 pixel
    logic [2:0]  m_amask, m_pmask;
    logic [9:0]  m_asplit, m_psplit;
    logic        m_pend, m_vsq;
    logic [10:0] exp_last;
    int          push_cnt = 0;
    wire         m_rise = vsync & ~m_vsq;

    function automatic logic [10:0] model_px(input logic [2:0] m, input logic [9:0] sp);
        logic [2:0] eff;
        logic [5:0] rgb;
        logic [1:0] id;
        eff = en & m;
        rgb = (hpos < sp) ? bgl : bgr;
        id  = 2'd3;
        if (eff != 3'b000) begin
            for (int k = 2; k >= 0; k--) begin
                if (eff[k]) begin
                    rgb = lrgb[k*6 +: 6];
                    id  = 2'(k);
                end
            end
        end
        if (!visible) begin
            rgb = '0;
            id  = '0;
        end
        return {rgb, id, hsync, vsync, visible};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_amask  <= 3'b111;
            m_pmask  <= 3'b111;
            m_asplit <= 10'd320;
            m_psplit <= 10'd320;
            m_pend   <= 1'b0;
            m_vsq    <= 1'b0;
        end else begin
            exp_last <= model_px(m_amask, m_asplit);
            push_cnt <= push_cnt + 1;
            m_vsq    <= vsync;
            if (cfg_wr) begin
                m_pmask  <= mask;
                m_psplit <= split;
            end
            if (m_rise) begin
                if (cfg_wr) begin
                    m_amask  <= mask;
                    m_asplit <= split;
                end else if (m_pend) begin
                    m_amask  <= m_pmask;
                    m_asplit <= m_psplit;
                end
            end
            m_pend <= cfg_wr ? !m_rise : (m_rise ? 1'b0 : m_pend);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        pixel_compositor_if #(.LAYERS(3), .COLOR_BITS(6), .HBITS(10)) bus ();

        assign bus.i_visible   = visible;
        assign bus.i_hsync     = hsync;
        assign bus.i_vsync     = vsync;
        assign bus.i_hpos      = hpos;
        assign bus.i_layer_en  = en;
        assign bus.i_layer_rgb = lrgb;
        assign bus.i_bg_left   = bgl;
        assign bus.i_bg_right  = bgr;
        assign bus.i_cfg_wr    = cfg_wr;
        assign bus.i_mask      = mask;
        assign bus.i_split     = split;

        pixel_compositor #(.LAYERS(3), .COLOR_BITS(6), .HBITS(10), .PIPE(P)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        wire [10:0] obs = {bus.o_rgb, bus.o_layer_id, bus.o_hsync, bus.o_vsync, bus.o_visible};

        logic [10:0] sb_q [$];
        int          seen = 0;

        always @(negedge clk) begin
            if (reset) begin
                sb_q.delete();
                seen <= push_cnt;
            end else begin
                if (push_cnt != seen) begin
                    sb_q.push_back(exp_last);
                    seen <= push_cnt;
                end
                if (sb_q.size() >= P) begin
                    check_val($sformatf("sb_pipe%0d", P), 32'(obs), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        visible = 1'b1; hsync = 1'b0; vsync = 1'b0; cfg_wr = 1'b0;
        hpos    = 10'd100; split = 10'd0; mask = 3'b000; en = 3'b111;
        lrgb    = {6'b000011, 6'b001100, 6'b110000};
        bgl     = 6'b101010; bgr = 6'b010101;

        // activity under reset must not reach the outputs
        repeat (3) begin
            @(negedge clk);
            hsync = ~hsync;
        end
        check_val("rst_hold_p2", 32'(g_dut[0].obs), 32'd0);
        check_val("rst_hold_p1", 32'(g_dut[1].obs), 32'd0);
        check_val("rst_hold_p4", 32'(g_dut[2].obs), 32'd0);

        @(negedge clk);
        reset = 1'b0; en = 3'b000; hsync = 1'b0; hpos = 10'd100;
        @(posedge clk); #1;
        check_val("lat_1clk", 32'(g_dut[0].obs), 32'd0);
        @(posedge clk); #1;
        check_val("lat_2clk_bg", 32'(g_dut[0].obs), 32'(pk(6'b101010, 2'd3, 1'b0, 1'b0, 1'b1)));

        // priority
        @(negedge clk); en = 3'b110;
        @(negedge clk); en = 3'b111;
        @(posedge clk); #1;
        check_val("prio_l1", 32'(g_dut[0].obs), 32'(pk(6'b001100, 2'd1, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        check_val("prio_l0", 32'(g_dut[0].obs), 32'(pk(6'b110000, 2'd0, 1'b0, 1'b0, 1'b1)));

        // mask written mid-frame only takes effect after the vsync rise
        @(negedge clk); en = 3'b001; cfg_wr = 1'b1; mask = 3'b110; split = 10'd320;
        @(negedge clk); cfg_wr = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mask_hold", 32'(g_dut[0].obs), 32'(pk(6'b110000, 2'd0, 1'b0, 1'b0, 1'b1)));
        vsync = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check_val("mask_rise_px", 32'(g_dut[0].obs), 32'(pk(6'b110000, 2'd0, 1'b0, 1'b1, 1'b1)));
        @(posedge clk); #1;
        check_val("mask_new", 32'(g_dut[0].obs), 32'(pk(6'b101010, 2'd3, 1'b0, 1'b1, 1'b1)));

        // config write on the same cycle as the vsync rise
        @(negedge clk); vsync = 1'b0; en = 3'b000;
        @(negedge clk); vsync = 1'b1; cfg_wr = 1'b1; mask = 3'b111; split = 10'd10; hpos = 10'd15;
        @(negedge clk); cfg_wr = 1'b0; hpos = 10'd9;
        @(posedge clk); #1;
        check_val("sim_old", 32'(g_dut[0].obs), 32'(pk(6'b101010, 2'd3, 1'b0, 1'b1, 1'b1)));
        @(negedge clk); hpos = 10'd10;
        @(posedge clk); #1;
        check_val("sim_left", 32'(g_dut[0].obs), 32'(pk(6'b101010, 2'd3, 1'b0, 1'b1, 1'b1)));
        @(posedge clk); #1;
        check_val("sim_right", 32'(g_dut[0].obs), 32'(pk(6'b010101, 2'd3, 1'b0, 1'b1, 1'b1)));

        // split extremes: max value then zero
        @(negedge clk); vsync = 1'b0; cfg_wr = 1'b1; split = 10'd1023;
        @(negedge clk); cfg_wr = 1'b0; vsync = 1'b1; hpos = 10'd1022;
        @(negedge clk); hpos = 10'd1022;
        @(negedge clk); hpos = 10'd1023;
        @(negedge clk); vsync = 1'b0; cfg_wr = 1'b1; split = 10'd0; hpos = 10'd0;
        @(negedge clk); cfg_wr = 1'b0; vsync = 1'b1;
        @(negedge clk); hpos = 10'd0;
        @(negedge clk); hpos = 10'd1023;

        // blanking and sync alignment
        @(negedge clk); visible = 1'b0; en = 3'b111;
        @(posedge clk);
        @(posedge clk); #1;
        check_val("blank", 32'(g_dut[0].obs), 32'(pk(6'b000000, 2'd0, 1'b0, 1'b1, 1'b0)));
        @(negedge clk); visible = 1'b1; hsync = 1'b1;
        @(negedge clk); hsync = 1'b0;
        @(posedge clk); #1;
        check_val("hs_align_p2", 32'(g_dut[0].obs), 32'(pk(6'b110000, 2'd0, 1'b1, 1'b1, 1'b1)));
        @(posedge clk);
        @(posedge clk); #1;
        check_val("hs_align_p4", 32'(g_dut[2].obs), 32'(pk(6'b110000, 2'd0, 1'b1, 1'b1, 1'b1)));

        // async reset with a pending config that must be discarded
        @(negedge clk); vsync = 1'b0; cfg_wr = 1'b1; mask = 3'b000; split = 10'd5; en = 3'b001; hpos = 10'd100;
        @(negedge clk); cfg_wr = 1'b0;
        #3 reset = 1'b1;
        #1;
        check_val("rst_async_p2", 32'(g_dut[0].obs), 32'd0);
        check_val("rst_async_p1", 32'(g_dut[1].obs), 32'd0);
        check_val("rst_async_p4", 32'(g_dut[2].obs), 32'd0);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); vsync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        check_val("rst_mask_def", 32'(g_dut[0].obs), 32'(pk(6'b110000, 2'd0, 1'b0, 1'b1, 1'b1)));
        @(negedge clk); en = 3'b000;
        @(posedge clk);
        @(posedge clk); #1;
        check_val("rst_split_def", 32'(g_dut[0].obs), 32'(pk(6'b101010, 2'd3, 1'b0, 1'b1, 1'b1)));

        // randomised traffic with occasional config writes and frame edges
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            visible = ($urandom_range(0, 7) != 0);
            hsync   = ($urandom_range(0, 15) == 0);
            vsync   = ((i % 40) < 3);
            hpos    = 10'($urandom);
            en      = 3'($urandom);
            lrgb    = 18'($urandom);
            bgl     = 6'($urandom);
            bgr     = 6'($urandom);
            cfg_wr  = ($urandom_range(0, 9) == 0);
            mask    = 3'($urandom);
            split   = 10'($urandom);
        end
        @(negedge clk); cfg_wr = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
